// File: rtl/ecc_patrol_scrubber_pkg.sv
// Shared types and AXI encodings for the ECC patrol scrubber.
// Holds the FSM state enum, RRESP/BRESP codes and the fixed AR/AW field values.
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B
    } scrub_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/ecc_patrol_scrubber_if.sv
// Single-beat AXI4 read/write channels between the scrubber (master) and the ECC controller (slave).
interface ecc_patrol_scrubber_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rdata, rresp, rlast, rvalid, output rready,
        output awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready,
        input  awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready
    );

endinterface

// File: rtl/ecc_sat_counter.sv
// Event counter that sticks at all-ones; count_o updates the cycle after inc_i.
module ecc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/ecc_patrol_scrubber.sv
// Patrol scrubber: one single-beat AXI read per word, CE/UE classification, optional write-back
// of corrected words (SCRUB_WRITEBACK_EN); every channel waits on its slave, R/B bounded by TIMEOUT.
module ecc_patrol_scrubber
    import ecc_scrub_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    REGION_WORDS = 1024,
    parameter int                    CNT_WIDTH    = 16,
    parameter int                    TIMEOUT      = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic [15:0]           interval_i,
    input  logic                  ue_clr_i,
    ecc_patrol_scrubber_if.master m_axi,
    output logic                  busy_o,
    output logic                  pass_done_o,
    output logic [CNT_WIDTH-1:0]  ce_count_o,
    output logic [CNT_WIDTH-1:0]  ue_count_o,
    output logic                  ue_o,
    output logic [ADDR_WIDTH-1:0] ue_addr_o,
    output logic                  timeout_o
);

    localparam int STEP = DATA_WIDTH / 8;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + ADDR_WIDTH'((REGION_WORDS - 1) * STEP);

    scrub_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [15:0]           ivl_q, ivl_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  ue_q, ue_d;
    logic [ADDR_WIDTH-1:0] ue_addr_q, ue_addr_d;
    logic                  timeout_q, timeout_d;
    logic                  pass_done_q, pass_done_d;
`ifdef SCRUB_WRITEBACK_EN
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
`endif

    logic ce_inc, ue_inc, ue_evt, advance;
    logic ar_vld, r_rdy, aw_vld, w_vld, b_rdy;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ivl_d       = ivl_q;
        tmr_d       = tmr_q;
        ue_d        = ue_q;
        ue_addr_d   = ue_addr_q;
        timeout_d   = timeout_q;
        pass_done_d = 1'b0;
`ifdef SCRUB_WRITEBACK_EN
        rdata_d     = rdata_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
`endif
        ce_inc  = 1'b0;
        ue_inc  = 1'b0;
        ue_evt  = 1'b0;
        advance = 1'b0;
        ar_vld  = 1'b0;
        r_rdy   = 1'b0;
        aw_vld  = 1'b0;
        w_vld   = 1'b0;
        b_rdy   = 1'b0;

        // Clear first so that a UE or timeout raised in the same cycle overrides it.
        if (ue_clr_i) begin
            ue_d      = 1'b0;
            ue_addr_d = '0;
            timeout_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    ivl_d   = interval_i;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable_i)         state_d = ST_IDLE;
                else if (ivl_q == '0)  state_d = ST_AR;
                else                   ivl_d   = ivl_q - 1'b1;
            end
            ST_AR: begin
                ar_vld = 1'b1;
                if (m_axi.arready) begin
                    state_d = ST_R;
                    tmr_d   = '0;
                end
            end
            ST_R: begin
                r_rdy = 1'b1;
                if (m_axi.rvalid) begin
                    unique case (m_axi.rresp)
                        RESP_OKAY:   advance = 1'b1;
                        RESP_EXOKAY: begin
                            ce_inc = 1'b1;
`ifdef SCRUB_WRITEBACK_EN
                            rdata_d   = m_axi.rdata;
                            aw_done_d = 1'b0;
                            w_done_d  = 1'b0;
                            state_d   = ST_AWW;
`else
                            advance   = 1'b1;
`endif
                        end
                        default: begin
                            ue_evt  = 1'b1;
                            advance = 1'b1;
                        end
                    endcase
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    ue_inc    = 1'b1;
                    advance   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`ifdef SCRUB_WRITEBACK_EN
            ST_AWW: begin
                aw_vld    = !aw_done_q;
                w_vld     = !w_done_q;
                aw_done_d = aw_done_q | m_axi.awready;
                w_done_d  = w_done_q | m_axi.wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_B;
                    tmr_d   = '0;
                end
            end
            ST_B: begin
                b_rdy = 1'b1;
                if (m_axi.bvalid) begin
                    ue_evt  = (m_axi.bresp != RESP_OKAY);
                    advance = 1'b1;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    ue_inc    = 1'b1;
                    advance   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (ue_evt) begin
            ue_inc = 1'b1;
            ue_d   = 1'b1;
            if (!ue_q || ue_clr_i) ue_addr_d = ptr_q;
        end

        if (advance) begin
            state_d = ST_IDLE;
            if (ptr_q == LAST_ADDR) begin
                ptr_d       = BASE_ADDR;
                pass_done_d = 1'b1;
            end else begin
                ptr_d = ptr_q + ADDR_WIDTH'(STEP);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= BASE_ADDR;
            ivl_q       <= '0;
            tmr_q       <= '0;
            ue_q        <= 1'b0;
            ue_addr_q   <= '0;
            timeout_q   <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ivl_q       <= ivl_d;
            tmr_q       <= tmr_d;
            ue_q        <= ue_d;
            ue_addr_q   <= ue_addr_d;
            timeout_q   <= timeout_d;
            pass_done_q <= pass_done_d;
        end
    end

`ifdef SCRUB_WRITEBACK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
`endif

    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_ce_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (ce_inc),
        .count_o (ce_count_o)
    );

    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_ue_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (ue_inc),
        .count_o (ue_count_o)
    );

    assign m_axi.araddr  = ptr_q;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = AXI_SIZE_8B;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arvalid = ar_vld;
    assign m_axi.rready  = r_rdy;
    assign m_axi.awvalid = aw_vld;
    assign m_axi.wvalid  = w_vld;
    assign m_axi.bready  = b_rdy;
`ifdef SCRUB_WRITEBACK_EN
    assign m_axi.awaddr  = ptr_q;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = AXI_SIZE_8B;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.wdata   = rdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = 1'b1;
`else
    assign m_axi.awaddr  = '0;
    assign m_axi.awlen   = '0;
    assign m_axi.awsize  = '0;
    assign m_axi.awburst = '0;
    assign m_axi.wdata   = '0;
    assign m_axi.wstrb   = '0;
    assign m_axi.wlast   = 1'b0;
`endif

    assign busy_o      = (state_q != ST_IDLE);
    assign pass_done_o = pass_done_q;
    assign ue_o        = ue_q;
    assign ue_addr_o   = ue_addr_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_ecc_patrol_scrubber.sv
// Randomized AXI slave plus word-index reference model for the patrol scrubber.
module tb_ecc_patrol_scrubber;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int RW   = 4;
    localparam int CW   = 3;
    localparam int TO   = 255;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [AW-1:0] BASE = 32'h0;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          enable_i = 1'b0;
    logic [15:0]   interval_i = '0;
    logic          ue_clr_i = 1'b0;
    logic          busy_o, pass_done_o, ue_o, timeout_o;
    logic [CW-1:0] ce_count_o, ue_count_o;
    logic [AW-1:0] ue_addr_o;

    ecc_patrol_scrubber_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    ecc_patrol_scrubber #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
        .REGION_WORDS(RW), .CNT_WIDTH(CW), .TIMEOUT(TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .enable_i    (enable_i),
        .interval_i  (interval_i),
        .ue_clr_i    (ue_clr_i),
        .m_axi       (axi),
        .busy_o      (busy_o),
        .pass_done_o (pass_done_o),
        .ce_count_o  (ce_count_o),
        .ue_count_o  (ue_count_o),
        .ue_o        (ue_o),
        .ue_addr_o   (ue_addr_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: which word is next, how many passes finished, and the status registers.
    int          m_idx = 0;
    int          m_passes = 0;
    int          m_ce = 0;
    int          m_ue = 0;
    bit          m_ue_flag = 0;
    bit          m_to = 0;
    logic [AW-1:0] m_ue_addr = '0;

    function automatic logic [AW-1:0] m_ptr();
        return BASE + AW'(m_idx * (DW / 8));
    endfunction

    function automatic int sat(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic m_advance();
        m_idx = (m_idx + 1) % RW;
        if (m_idx == 0) m_passes++;
    endtask

    task automatic m_ue_event(input bit clr);
        m_ue = sat(m_ue);
        if (!m_ue_flag || clr) m_ue_addr = m_ptr();
        m_ue_flag = 1;
    endtask

    int pd_cnt = 0;
    bit aw_seen = 0;
    always @(posedge clk_i) begin
        if (pass_done_o) pd_cnt++;
        if (axi.awvalid) aw_seen = 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_status(input string where);
        check_eq({where, "_ce"}, ce_count_o, m_ce);
        check_eq({where, "_ue"}, ue_count_o, m_ue);
        check_eq({where, "_ue_o"}, ue_o, m_ue_flag);
        check_eq({where, "_ue_addr"}, ue_addr_o, m_ue_addr);
        check_eq({where, "_timeout"}, timeout_o, m_to);
    endtask

    task automatic clr_pulse();
        ue_clr_i = 1'b1;
        tick();
        ue_clr_i = 1'b0;
        m_ue_flag = 0;
        m_ue_addr = '0;
        m_to = 0;
        check_status("after_clr");
    endtask

    task automatic txn(input logic [1:0] resp, input logic [63:0] data, input int rdly,
                       input int arstall, input bit drop_en, input bit clr,
                       input logic [1:0] bresp, input bit withhold);
        logic [AW-1:0] a0;
        int i;
        i = 0;
        while (!axi.arvalid && i < 400) begin
            tick();
            i++;
        end
        check_eq("ar_seen", axi.arvalid, 1'b1);
        check_eq("araddr", axi.araddr, m_ptr());
        check_eq("ar_fixed", {axi.arlen, axi.arsize, axi.arburst}, {8'd0, 3'd3, 2'b01});
        check_eq("pass_cnt", pd_cnt, m_passes);
        check_status("pre_txn");
        a0 = axi.araddr;
        for (int k = 0; k < arstall; k++) begin
            if (drop_en) enable_i = 1'b0;
            tick();
            check_eq("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, a0});
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;

        if (withhold) begin
            check_eq("rready_on", axi.rready, 1'b1);
            repeat (TO) tick();
            axi.rvalid = 1'b1;
            axi.rresp  = 2'b00;
            check_eq("late_rready", axi.rready, 1'b0);
            tick();
            axi.rvalid = 1'b0;
            m_to = 1;
            m_ue = sat(m_ue);
            m_advance();
            check_eq("timeout_o", timeout_o, m_to);
            check_eq("timeout_ue", ue_count_o, m_ue);
            return;
        end

        repeat (rdly) tick();
        check_eq("rready", axi.rready, 1'b1);
        axi.rvalid = 1'b1;
        axi.rdata  = data;
        axi.rresp  = resp;
        ue_clr_i   = clr;
        tick();
        axi.rvalid = 1'b0;
        ue_clr_i   = 1'b0;
        if (clr) begin
            m_ue_flag = 0;
            m_ue_addr = '0;
            m_to = 0;
        end

        if (resp == 2'b00) begin
            m_advance();
        end else if (resp == 2'b01) begin
            m_ce = sat(m_ce);
`ifdef SCRUB_WRITEBACK_EN
            begin
                bit awd, wd;
                int da, dw, bd;
                awd = 0; wd = 0;
                da = $urandom_range(0, 3);
                dw = $urandom_range(0, 3);
                bd = $urandom_range(0, 2);
                i = 0;
                while (!axi.awvalid && i < 20) begin
                    tick();
                    i++;
                end
                check_eq("awaddr", axi.awaddr, m_ptr());
                check_eq("wdata", axi.wdata, data);
                check_eq("w_fixed", {axi.wstrb, axi.wlast, axi.awlen, axi.awsize, axi.awburst},
                         {8'hFF, 1'b1, 8'd0, 3'd3, 2'b01});
                for (int c = 0; c < 30 && !(awd && wd); c++) begin
                    if (awd) check_eq("aw_drop", axi.awvalid, 1'b0);
                    if (wd)  check_eq("w_drop", axi.wvalid, 1'b0);
                    axi.awready = (c >= da);
                    axi.wready  = (c >= dw);
                    if (axi.awvalid && axi.awready) awd = 1;
                    if (axi.wvalid && axi.wready)   wd  = 1;
                    tick();
                end
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                check_eq("aw_w_done", {awd, wd}, 2'b11);
                repeat (bd) tick();
                check_eq("bready", axi.bready, 1'b1);
                axi.bvalid = 1'b1;
                axi.bresp  = bresp;
                tick();
                axi.bvalid = 1'b0;
                if (bresp != 2'b00) m_ue_event(1'b0);
            end
`endif
            m_advance();
        end else begin
            m_ue_event(clr);
            m_advance();
        end

        if (drop_en) begin
            bit any_ar;
            any_ar = 0;
            repeat (3) tick();
            check_eq("busy_idle", busy_o, 1'b0);
            repeat (10) begin
                if (axi.arvalid) any_ar = 1;
                tick();
            end
            check_eq("no_ar_disabled", any_ar, 1'b0);
            enable_i = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d", total);
        $fatal(1);
    end

    initial begin
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b1;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                                busy_o, pass_done_o}, 7'd0);
        check_eq("rst_araddr", axi.araddr, BASE);
        check_status("reset");
        rst_n_i = 1'b1;
        tick();
        enable_i = 1'b1;

        // Clean pass over all four words.
        for (int w = 0; w < RW; w++) txn(2'b00, 64'h0, 0, 0, 0, 0, 2'b00, 0);
        // Corrected word at 0x10 carrying 0xA5.
        txn(2'b00, 64'h0, 1, 0, 0, 0, 2'b00, 0);
        txn(2'b00, 64'h0, 0, 0, 0, 0, 2'b00, 0);
        txn(2'b01, 64'hA5, 0, 0, 0, 0, 2'b00, 0);
        txn(2'b00, 64'h0, 0, 0, 0, 0, 2'b00, 0);
        // Uncorrectable at 0x8 and 0x18; first address sticks.
        txn(2'b00, 64'h0, 0, 0, 0, 0, 2'b00, 0);
        txn(2'b10, 64'h0, 2, 0, 0, 0, 2'b00, 0);
        txn(2'b00, 64'h0, 0, 0, 0, 0, 2'b00, 0);
        txn(2'b10, 64'h0, 0, 0, 0, 0, 2'b00, 0);
        check_status("two_ue");
        clr_pulse();
        // Missing read response, then the pointer must have moved on.
        txn(2'b00, 64'h0, 0, 0, 0, 0, 2'b00, 1);
        txn(2'b11, 64'h0, 0, 0, 0, 1, 2'b00, 0);
        check_status("clr_vs_set");
        // Slow arready with enable dropped while the read address is pending.
        txn(2'b00, 64'h0, 1, 10, 1, 0, 2'b00, 0);

        for (int n = 0; n < 40; n++) begin
            int r;
            logic [1:0] resp;
            r = $urandom_range(0, 7);
            resp = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
            interval_i = 16'($urandom_range(0, 3));
            txn(resp, {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 3), 0,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00, 0);
        end

        enable_i = 1'b0;
        repeat (8) tick();
        check_eq("final_pass_cnt", pd_cnt, m_passes);
        check_eq("final_busy", busy_o, 1'b0);
        check_status("final");
`ifndef SCRUB_WRITEBACK_EN
        check_eq("no_awvalid", aw_seen, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
